// File: rtl/dco_freq_meter_pkg.sv
// Shared types and constants for the DCO frequency meter and the DCO block it characterises.
package dco_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GATE = 2'd1,
    ST_HOLD = 2'd2
  } meter_state_e;

  localparam int GATE_CYCLES_DEF = 1000;
  localparam int CNT_W_DEF       = 16;

  // DCO period table endpoints, shared with the DCO block
  localparam int DCO_PERIOD_MIN   = 3;
  localparam int DCO_PERIOD_MAX   = 10;
  localparam int DCO_PERIOD_CODE0 = 50;

endpackage

// File: rtl/dco_freq_meter_if.sv
// Result handshake between the frequency meter (master) and the readout logic (slave).
interface dco_freq_meter_if #(
  parameter int CNT_W = 16
);
  logic [CNT_W-1:0] count_out;
  logic             count_valid;
  logic             count_ready;
  logic             overflow;
  logic             busy;

  modport master (
    output count_out,
    output count_valid,
    output overflow,
    output busy,
    input  count_ready
  );

  modport slave (
    input  count_out,
    input  count_valid,
    input  overflow,
    input  busy,
    output count_ready
  );
endinterface

// File: rtl/dco_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input followed by a one-cycle rising-edge pulse.
module dco_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic rise_p
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_edge;

  // Synchroniser chain and edge-history flop; free-running, independent of enable
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_edge <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d_async};
      r_edge <= r_sync[SYNC_STAGES-1];
    end
  end

  assign rise_p = r_sync[SYNC_STAGES-1] & ~r_edge;

endmodule

// File: rtl/dco_freq_meter.sv
// Counts synchronised DCO rising edges over a window of GATE_CYCLES enabled clk cycles and
// hands the (saturating) count to the readout logic over a valid/ready handshake.
module dco_freq_meter
  import dco_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             dco_in,
  input  logic             start,
  input  logic             cont,
  dco_freq_meter_if.master m_if
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  meter_state_e     r_state, w_state_nxt;
  logic [GW-1:0]    r_gate_cnt, w_gate_nxt;
  logic [CNT_W-1:0] r_edge_cnt, w_edge_nxt;
  logic             r_sat, w_sat_nxt;
  logic             w_load;
  logic             w_rise_p;
  logic [CNT_W-1:0] r_count_out;
  logic             r_overflow;
  logic             r_count_valid;
  logic             r_busy;

  dco_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
    .clk     (clk),
    .rst     (rst),
    .d_async (dco_in),
    .rise_p  (w_rise_p)
  );

  // Next-state, counter and result-load decisions
  always_comb begin
    w_state_nxt = r_state;
    w_gate_nxt  = r_gate_cnt;
    w_edge_nxt  = r_edge_cnt;
    w_sat_nxt   = r_sat;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_gate_nxt = '0;
        w_edge_nxt = '0;
        w_sat_nxt  = 1'b0;
        if (ena && (start || cont)) begin
          w_state_nxt = ST_GATE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GATE: begin
        if (ena) begin
          // An edge at full scale marks saturation instead of wrapping
          if (w_rise_p && (r_edge_cnt == CNT_MAX)) begin
            w_sat_nxt = 1'b1;
          end else if (w_rise_p) begin
            w_edge_nxt = r_edge_cnt + CNT_W'(1);
          end else begin
            w_edge_nxt = r_edge_cnt;
          end
          if (r_gate_cnt == GATE_LAST) begin
            w_state_nxt = ST_HOLD;
            w_gate_nxt  = '0;
            w_load      = 1'b1;
          end else begin
            w_gate_nxt  = r_gate_cnt + GW'(1);
          end
        end else begin
          w_state_nxt = ST_GATE;
        end
      end
      ST_HOLD: begin
        if (r_count_valid && m_if.count_ready) begin
          w_state_nxt = cont ? ST_GATE : ST_IDLE;
          w_gate_nxt  = '0;
          w_edge_nxt  = '0;
          w_sat_nxt   = 1'b0;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_gate_cnt    <= '0;
      r_edge_cnt    <= '0;
      r_sat         <= 1'b0;
      r_count_out   <= '0;
      r_overflow    <= 1'b0;
      r_count_valid <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_gate_cnt    <= w_gate_nxt;
      r_edge_cnt    <= w_edge_nxt;
      r_sat         <= w_sat_nxt;
      r_count_valid <= (w_state_nxt == ST_HOLD);
      r_busy        <= (w_state_nxt != ST_IDLE);
      if (w_load) begin
        r_count_out <= w_edge_nxt;
        r_overflow  <= w_sat_nxt;
      end else begin
        r_count_out <= r_count_out;
        r_overflow  <= r_overflow;
      end
    end
  end

  assign m_if.count_out   = r_count_out;
  assign m_if.overflow    = r_overflow;
  assign m_if.count_valid = r_count_valid;
  assign m_if.busy        = r_busy;

endmodule

// File: tb/tb_dco_freq_meter.sv
// Three meter instances (gate 220/16b, gate 224/16b, gate 220/4b) share one stimulus stream and
// are checked every cycle against a behavioural model plus hand-computed expectations.
module tb_dco_freq_meter;
  import dco_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b1;
  logic dco_in = 1'b0;
  logic start = 1'b0;
  logic cont = 1'b0;
  logic ready = 1'b1;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;
  int cyc = 0;
  int dco_half = 0;
  int dco_ph = 0;
  int el;

  always #5 clk = ~clk;

  dco_freq_meter_if #(.CNT_W(16)) if_a ();
  dco_freq_meter_if #(.CNT_W(16)) if_b ();
  dco_freq_meter_if #(.CNT_W(4))  if_c ();
  assign if_a.count_ready = ready;
  assign if_b.count_ready = ready;
  assign if_c.count_ready = ready;

  dco_freq_meter #(.GATE_CYCLES(220), .CNT_W(16), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .ena(ena), .dco_in(dco_in), .start(start), .cont(cont), .m_if(if_a));
  dco_freq_meter #(.GATE_CYCLES(224), .CNT_W(16), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst(rst), .ena(ena), .dco_in(dco_in), .start(start), .cont(cont), .m_if(if_b));
  dco_freq_meter #(.GATE_CYCLES(220), .CNT_W(4), .SYNC_STAGES(2)) dut_c (
    .clk(clk), .rst(rst), .ena(ena), .dco_in(dco_in), .start(start), .cont(cont), .m_if(if_c));

  logic [15:0] act_out [3];
  logic        act_valid [3];
  logic        act_ovf [3];
  logic        act_busy [3];
  assign act_out[0] = if_a.count_out;
  assign act_out[1] = if_b.count_out;
  assign act_out[2] = {12'd0, if_c.count_out};
  assign act_valid[0] = if_a.count_valid;
  assign act_valid[1] = if_b.count_valid;
  assign act_valid[2] = if_c.count_valid;
  assign act_ovf[0] = if_a.overflow;
  assign act_ovf[1] = if_b.overflow;
  assign act_ovf[2] = if_c.overflow;
  assign act_busy[0] = if_a.busy;
  assign act_busy[1] = if_b.busy;
  assign act_busy[2] = if_c.busy;

  // Model: phase 0 idle, 1 measuring, 2 result held; raw is the true (unbounded) edge count
  int gate_len [3] = '{220, 224, 220};
  int max_cnt  [3] = '{65535, 65535, 15};
  int m_ph   [3] = '{0, 0, 0};
  int m_raw  [3] = '{0, 0, 0};
  int m_left [3] = '{0, 0, 0};
  int m_out  [3] = '{0, 0, 0};
  int m_ovf  [3] = '{0, 0, 0};
  // hist[j] = dco_in seen at the (j+1)-th previous clock edge, as the synchroniser sees it
  bit hist [4] = '{0, 0, 0, 0};

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit e;
    e = hist[1] & ~hist[2];
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_ph[i] = 0; m_raw[i] = 0; m_left[i] = 0; m_out[i] = 0; m_ovf[i] = 0;
      end else if (m_ph[i] == 0) begin
        if (ena && (start || cont)) begin
          m_ph[i] = 1; m_raw[i] = 0; m_left[i] = gate_len[i];
        end
      end else if (m_ph[i] == 1) begin
        if (ena) begin
          m_raw[i] += int'(e);
          m_left[i]--;
          if (m_left[i] == 0) begin
            m_ph[i]  = 2;
            m_out[i] = (m_raw[i] > max_cnt[i]) ? max_cnt[i] : m_raw[i];
            m_ovf[i] = (m_raw[i] > max_cnt[i]) ? 1 : 0;
          end
        end
      end else if (ready) begin
        m_ph[i] = cont ? 1 : 0; m_raw[i] = 0; m_left[i] = gate_len[i];
      end
    end
    if (rst) begin
      hist = '{0, 0, 0, 0};
    end else begin
      hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = dco_in;
    end
  endtask

  always @(posedge clk) model_step();

  // Per-cycle comparison of every instance against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("cmp%0d.count_out", i), int'(act_out[i]), m_out[i]);
        chk($sformatf("cmp%0d.overflow", i), int'(act_ovf[i]), m_ovf[i]);
        chk($sformatf("cmp%0d.count_valid", i), int'(act_valid[i]), (m_ph[i] == 2) ? 1 : 0);
        chk($sformatf("cmp%0d.busy", i), int'(act_busy[i]), (m_ph[i] != 0) ? 1 : 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    cyc++;
    #2;
    if (dco_half > 0) begin
      dco_ph++;
      if (dco_ph >= dco_half) begin
        dco_ph = 0;
        dco_in = ~dco_in;
      end
    end
  endtask

  task automatic dco_restart(input int half);
    dco_half = half;
    dco_in = 1'b0;
    dco_ph = 0;
  endtask

  task automatic drain();
    ready = 1'b1;
    cont = 1'b0;
    repeat (8) tick();
  endtask

  // Ticks until instance idx raises count_valid; optional ena gap after tick number gap_at
  task automatic wait_valid(input int idx, input int budget, input int gap_at, input int gap_len,
                            output int elapsed);
    elapsed = -1;
    for (int n = 1; n <= budget; n++) begin
      tick();
      start = 1'b0;
      if (gap_len > 0 && n == gap_at) ena = 1'b0;
      if (gap_len > 0 && n == gap_at + gap_len) ena = 1'b1;
      if (act_valid[idx]) begin
        elapsed = n;
        break;
      end
    end
    ena = 1'b1;
    start = 1'b0;
    if (elapsed < 0) chk($sformatf("timeout.dut%0d", idx), 0, 1);
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset.count_out", int'(act_out[0]), 0);
    chk("reset.count_valid", int'(act_valid[0]), 0);
    chk("reset.overflow", int'(act_ovf[0]), 0);
    chk("reset.busy", int'(act_busy[0]), 0);

    // Nominal: period 22 over 220 cycles
    dco_restart(11);
    repeat (4) tick();
    start = 1'b1;
    wait_valid(0, 400, 0, 0, el);
    chk("nominal.latency", el, 221);
    chk("nominal.count", int'(act_out[0]), 10);
    chk("nominal.overflow", int'(act_ovf[0]), 0);
    drain();

    // start while disabled is dropped, not queued
    ena = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("ena0.start_ignored", int'(act_busy[0]), 0);
    ena = 1'b1;
    repeat (3) tick();
    chk("ena0.not_queued", int'(act_busy[0]), 0);

    // Fastest code: period 8 over 224 cycles, all phase offsets
    for (int p = 0; p < 8; p++) begin
      dco_restart(4);
      repeat (4 + p) tick();
      start = 1'b1;
      wait_valid(1, 400, 0, 0, el);
      chk($sformatf("fast.ph%0d.count", p), int'(act_out[1]), 28);
      drain();
    end

    // Saturation on the 4-bit instance, then a small count clears the flag
    dco_restart(4);
    repeat (4) tick();
    start = 1'b1;
    wait_valid(2, 400, 0, 0, el);
    chk("sat.count", int'(act_out[2]), 15);
    chk("sat.overflow", int'(act_ovf[2]), 1);
    drain();
    dco_restart(51);
    repeat (4) tick();
    start = 1'b1;
    wait_valid(2, 400, 0, 0, el);
    chk("code0.count", int'(act_out[2]), 2);
    chk("code0.overflow", int'(act_ovf[2]), 0);
    drain();

    // Continuous mode with a 50-cycle consumer stall
    dco_restart(11);
    repeat (4) tick();
    cont = 1'b1;
    ready = 1'b0;
    start = 1'b1;
    wait_valid(0, 400, 0, 0, el);
    chk("b2b.first.latency", el, 221);
    chk("b2b.first.count", int'(act_out[0]), 10);
    repeat (50) tick();
    chk("b2b.stall.count", int'(act_out[0]), 10);
    chk("b2b.stall.valid", int'(act_valid[0]), 1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("b2b.valid_drop", int'(act_valid[0]), 0);
    chk("b2b.regate_busy", int'(act_busy[0]), 1);
    wait_valid(0, 400, 0, 0, el);
    chk("b2b.second.latency", el, 220);
    chk("b2b.second.count", int'(act_out[0]), 10);
    drain();

    // 44-cycle enable gap mid-gate
    dco_restart(11);
    repeat (4) tick();
    start = 1'b1;
    wait_valid(0, 500, 101, 44, el);
    chk("enagap.latency", el, 265);
    chk("enagap.count", int'(act_out[0]), 10);
    drain();

    // Reset at gate cycle 100, then a clean measurement
    dco_restart(11);
    repeat (4) tick();
    start = 1'b1;
    repeat (101) begin
      tick();
      start = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid.busy", int'(act_busy[0]), 0);
    chk("rstmid.count_valid", int'(act_valid[0]), 0);
    chk("rstmid.count_out", int'(act_out[0]), 0);
    repeat (6) tick();
    start = 1'b1;
    wait_valid(0, 400, 0, 0, el);
    chk("rstmid.after.latency", el, 221);
    chk("rstmid.after.count", int'(act_out[0]), 10);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
